leve1_trap_ctrl: RTL and testbench

Trap and xRET sequencer for the LEVE1 core. On an accepted exception, interrupt, MRET or SRET it takes ownership of the CSR file's single read/write port and runs a fixed multi-cycle read/write sequence: save the trap context, update mstatus/sstatus, and switch privilege mode. It then emits a one-cycle redirect to the fetch stage. It sits between the execute/commit stage and the CSR file, and holds the architectural privilege mode.

---
 rtl/leve1_trap_ctrl_if.sv | 37 +++
 rtl/leve1_trap_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_leve1_trap_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/leve1_trap_ctrl_if.sv
// +----------------------------------------------------------------------------
// | leve1_trap_ctrl_if : request, redirect and CSR-port bundle for the trap
// |                      and xRET sequencer
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

interface leve1_trap_ctrl_if;
  logic        TRAP_VALID;
  logic [63:0] TRAP_CAUSE;
  logic [63:0] TRAP_EPC;
  logic [63:0] TRAP_TVAL;
  logic        XRET_VALID;
  logic        XRET_S;
  logic        READY;
  logic        BUSY;
  logic [11:0] CSR_RA;
  logic [63:0] CSR_RD;
  logic [1:0]  CSR_WCMD;
  logic [11:0] CSR_WA;
  logic [63:0] CSR_WD;
  logic        REDIRECT_VALID;
  logic [63:0] REDIRECT_PC;
  logic [1:0]  MODE;

  modport slave (
    input  TRAP_VALID, TRAP_CAUSE, TRAP_EPC, TRAP_TVAL, XRET_VALID, XRET_S, CSR_RD,
    output READY, BUSY, CSR_RA, CSR_WCMD, CSR_WA, CSR_WD, REDIRECT_VALID, REDIRECT_PC, MODE
  );

  modport master (
    output TRAP_VALID, TRAP_CAUSE, TRAP_EPC, TRAP_TVAL, XRET_VALID, XRET_S, CSR_RD,
    input  READY, BUSY, CSR_RA, CSR_WCMD, CSR_WA, CSR_WD, REDIRECT_VALID, REDIRECT_PC, MODE
  );
endinterface

`default_nettype wire

// File: rtl/leve1_trap_ctrl.sv
// +----------------------------------------------------------------------------
// | leve1_trap_ctrl : owns the CSR port to save/restore trap context, switch
// |                   privilege mode and redirect fetch
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module leve1_trap_ctrl (
  input  logic             CLK,
  input  logic             RSTn,
  leve1_trap_ctrl_if.slave bus
);

  localparam logic [1:0] CSR_NONE  = 2'b00;
  localparam logic [1:0] CSR_WRITE = 2'b01;
  localparam logic [1:0] MODE_M    = 2'b11;
  localparam logic [1:0] MODE_S    = 2'b01;

  typedef enum logic [3:0] {
    ST_IDLE, ST_RD_DELEG, ST_RD_VEC, ST_WR_EPC, ST_WR_CAUSE,
    ST_WR_TVAL, ST_WR_STAT, ST_DONE, ST_RD_EPC, ST_RD_STAT
  } state_t;

  typedef enum logic [1:0] {K_TRAP, K_MRET, K_SRET} kind_t;

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic        deleg_q, deleg_d;
  logic [63:0] cause_q, cause_d;
  logic [63:0] epc_q, epc_d;
  logic [63:0] tval_q, tval_d;
  logic [63:0] tgt_q, tgt_d;
  logic [63:0] redirect_pc_q, redirect_pc_d;
  logic [1:0]  mode_q, mode_d;

  logic [11:0] csr_ra;
  logic [1:0]  csr_wcmd;
  logic [11:0] csr_wa;
  logic [63:0] csr_wd;
  logic        s_side;
  logic [63:0] tvec_base;
  logic [63:0] trap_tgt;

  // S-level CSRs are used by delegated traps and by SRET.
  assign s_side    = (kind_q == K_TRAP) ? deleg_q : (kind_q == K_SRET);
  assign tvec_base = tgt_q & ~64'd3;
  assign trap_tgt  = (tgt_q[1:0] == 2'b01 && cause_q[63])
                   ? tvec_base + {56'd0, cause_q[5:0], 2'b00}
                   : tvec_base;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q       <= ST_IDLE;
      kind_q        <= K_TRAP;
      deleg_q       <= 1'b0;
      cause_q       <= '0;
      epc_q         <= '0;
      tval_q        <= '0;
      tgt_q         <= '0;
      redirect_pc_q <= '0;
      mode_q        <= MODE_M;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      deleg_q       <= deleg_d;
      cause_q       <= cause_d;
      epc_q         <= epc_d;
      tval_q        <= tval_d;
      tgt_q         <= tgt_d;
      redirect_pc_q <= redirect_pc_d;
      mode_q        <= mode_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    deleg_d       = deleg_q;
    cause_d       = cause_q;
    epc_d         = epc_q;
    tval_d        = tval_q;
    tgt_d         = tgt_q;
    redirect_pc_d = redirect_pc_q;
    mode_d        = mode_q;
    csr_ra        = 12'h000;
    csr_wcmd      = CSR_NONE;
    csr_wa        = 12'h000;
    csr_wd        = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.TRAP_VALID) begin
          kind_d  = K_TRAP;
          deleg_d = 1'b0;
          cause_d = bus.TRAP_CAUSE;
          epc_d   = bus.TRAP_EPC;
          tval_d  = bus.TRAP_TVAL;
          state_d = ST_RD_DELEG;
        end else if (bus.XRET_VALID) begin
          kind_d  = bus.XRET_S ? K_SRET : K_MRET;
          state_d = ST_RD_EPC;
        end
      end
      ST_RD_DELEG: begin
        csr_ra  = 12'h302;
        state_d = ST_RD_VEC;
      end
      ST_RD_VEC: begin
        // Interrupts are never delegated by medeleg; M-mode traps stay in M.
        deleg_d = (mode_q != MODE_M) && !cause_q[63] && bus.CSR_RD[cause_q[5:0]];
        csr_ra  = deleg_d ? 12'h105 : 12'h305;
        state_d = ST_WR_EPC;
      end
      ST_WR_EPC: begin
        tgt_d    = bus.CSR_RD;
        csr_wcmd = CSR_WRITE;
        csr_wa   = s_side ? 12'h141 : 12'h341;
        csr_wd   = {epc_q[63:1], 1'b0};
        state_d  = ST_WR_CAUSE;
      end
      ST_WR_CAUSE: begin
        csr_wcmd = CSR_WRITE;
        csr_wa   = s_side ? 12'h142 : 12'h342;
        csr_wd   = cause_q;
        state_d  = ST_WR_TVAL;
      end
      ST_WR_TVAL: begin
        csr_wcmd = CSR_WRITE;
        csr_wa   = s_side ? 12'h143 : 12'h343;
        csr_wd   = tval_q;
        csr_ra   = s_side ? 12'h100 : 12'h300;
        state_d  = ST_WR_STAT;
      end
      ST_RD_EPC: begin
        csr_ra  = s_side ? 12'h141 : 12'h341;
        state_d = ST_RD_STAT;
      end
      ST_RD_STAT: begin
        tgt_d   = bus.CSR_RD;
        csr_ra  = s_side ? 12'h100 : 12'h300;
        state_d = ST_WR_STAT;
      end
      ST_WR_STAT: begin
        csr_wcmd = CSR_WRITE;
        csr_wa   = s_side ? 12'h100 : 12'h300;
        csr_wd   = bus.CSR_RD;
        case (kind_q)
          K_TRAP: begin
            redirect_pc_d = trap_tgt;
            if (deleg_q) begin
              csr_wd[5] = bus.CSR_RD[1];
              csr_wd[1] = 1'b0;
              csr_wd[8] = mode_q[0];
              mode_d    = MODE_S;
            end else begin
              csr_wd[7]     = bus.CSR_RD[3];
              csr_wd[3]     = 1'b0;
              csr_wd[12:11] = mode_q;
              mode_d        = MODE_M;
            end
          end
          K_MRET: begin
            redirect_pc_d = tgt_q;
            csr_wd[3]     = bus.CSR_RD[7];
            csr_wd[7]     = 1'b1;
            csr_wd[12:11] = 2'b00;
            mode_d        = bus.CSR_RD[12:11];
          end
          default: begin
            redirect_pc_d = tgt_q;
            csr_wd[1]     = bus.CSR_RD[5];
            csr_wd[5]     = 1'b1;
            csr_wd[8]     = 1'b0;
            mode_d        = {1'b0, bus.CSR_RD[8]};
          end
        endcase
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.READY          = (state_q == ST_IDLE);
  assign bus.BUSY           = (state_q != ST_IDLE);
  assign bus.CSR_RA         = csr_ra;
  assign bus.CSR_WCMD       = csr_wcmd;
  assign bus.CSR_WA         = csr_wa;
  assign bus.CSR_WD         = csr_wd;
  assign bus.REDIRECT_VALID = (state_q == ST_DONE);
  assign bus.REDIRECT_PC    = redirect_pc_q;
  assign bus.MODE           = mode_q;

endmodule

`default_nettype wire

// File: tb/tb_leve1_trap_ctrl.sv
// +----------------------------------------------------------------------------
// | tb_leve1_trap_ctrl : directed bench with a small CSR file model
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_leve1_trap_ctrl;

  logic CLK;
  logic RSTn;
  int   n_cmp;
  int   n_err;

  leve1_trap_ctrl_if bus ();

  leve1_trap_ctrl dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // CSR file model: registered read, write on the clock edge, plus a backdoor.
  logic [63:0] csr [0:4095];
  logic        bd_we;
  logic [11:0] bd_addr;
  logic [63:0] bd_data;
  logic [63:0] csr_rd_q;

  always @(posedge CLK) begin
    csr_rd_q <= csr[bus.CSR_RA];
    if (bus.CSR_WCMD == 2'b01) csr[bus.CSR_WA] <= bus.CSR_WD;
    if (bd_we) csr[bd_addr] <= bd_data;
  end
  assign bus.CSR_RD = csr_rd_q;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic csr_set(input logic [11:0] a, input logic [63:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    @(posedge CLK);
    #1 bd_we = 1'b0;
    @(negedge CLK);
  endtask

  // Starts at a negedge with the request already driven (cycle 0).
  task automatic run_seq(output int rcyc, output logic [63:0] rpc, output logic [1:0] rmode,
                         output logic rdy_after, output logic busy1);
    rcyc = -1; rpc = '0; rmode = '0; rdy_after = 1'b0; busy1 = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (c == 1) begin
        busy1          = bus.BUSY;
        bus.TRAP_VALID = 1'b0;
        bus.XRET_VALID = 1'b0;
      end
      if (bus.REDIRECT_VALID && rcyc < 0) begin
        rcyc  = c;
        rpc   = bus.REDIRECT_PC;
        rmode = bus.MODE;
      end
      if (rcyc >= 0 && c == rcyc + 1) rdy_after = bus.READY;
      @(negedge CLK);
    end
  endtask

  task automatic set_trap(input logic [63:0] cause, input logic [63:0] epc, input logic [63:0] tval);
    bus.TRAP_CAUSE = cause;
    bus.TRAP_EPC   = epc;
    bus.TRAP_TVAL  = tval;
    bus.TRAP_VALID = 1'b1;
  endtask

  int          rcyc;
  logic [63:0] rpc;
  logic [1:0]  rmode;
  logic        rdy_after;
  logic        busy1;
  int          r1_cyc, r2_cyc, n_redir;
  logic [63:0] r1_pc, r2_pc;
  logic [1:0]  r1_mode, r2_mode;
  logic        rdy8, busy9;

  initial begin
    n_cmp = 0; n_err = 0;
    RSTn = 1'b0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    bus.TRAP_VALID = 1'b0; bus.TRAP_CAUSE = '0; bus.TRAP_EPC = '0; bus.TRAP_TVAL = '0;
    bus.XRET_VALID = 1'b0; bus.XRET_S = 1'b0;
    repeat (3) @(negedge CLK);

    check_eq("rst_ready", bus.READY, 1);
    check_eq("rst_busy", bus.BUSY, 0);
    check_eq("rst_wcmd", bus.CSR_WCMD, 0);
    check_eq("rst_ra", bus.CSR_RA, 0);
    check_eq("rst_redir", bus.REDIRECT_VALID, 0);
    check_eq("rst_pc", bus.REDIRECT_PC, 0);
    check_eq("rst_mode", bus.MODE, 2'b11);
    RSTn = 1'b1;
    @(negedge CLK);

    // M-mode trap, no delegation
    csr_set(12'h302, 64'h0);
    csr_set(12'h305, 64'h8000_1000);
    csr_set(12'h300, 64'h8);
    set_trap(64'd2, 64'h8000_0101, 64'hDEAD_BEEF);
    run_seq(rcyc, rpc, rmode, rdy_after, busy1);
    check_eq("t1_busy1", busy1, 1);
    check_eq("t1_cyc", rcyc, 7);
    check_eq("t1_pc", rpc, 64'h8000_1000);
    check_eq("t1_mode", rmode, 2'b11);
    check_eq("t1_ready", rdy_after, 1);
    check_eq("t1_mepc", csr[12'h341], 64'h8000_0100);
    check_eq("t1_mcause", csr[12'h342], 64'd2);
    check_eq("t1_mtval", csr[12'h343], 64'hDEAD_BEEF);
    check_eq("t1_mstatus", csr[12'h300], 64'h1880);

    // MRET to U mode
    csr_set(12'h341, 64'h8000_3000);
    csr_set(12'h300, 64'h80);
    bus.XRET_S = 1'b0; bus.XRET_VALID = 1'b1;
    run_seq(rcyc, rpc, rmode, rdy_after, busy1);
    check_eq("mu_cyc", rcyc, 4);
    check_eq("mu_pc", rpc, 64'h8000_3000);
    check_eq("mu_mode", rmode, 2'b00);
    check_eq("mu_ready", rdy_after, 1);
    check_eq("mu_mstatus", csr[12'h300], 64'h88);

    // Delegated exception from U
    csr_set(12'h302, 64'h100);
    csr_set(12'h105, 64'h8020_0000);
    csr_set(12'h100, 64'h2);
    set_trap(64'd8, 64'h8000_0205, 64'h55);
    run_seq(rcyc, rpc, rmode, rdy_after, busy1);
    check_eq("t2_cyc", rcyc, 7);
    check_eq("t2_pc", rpc, 64'h8020_0000);
    check_eq("t2_mode", rmode, 2'b01);
    check_eq("t2_sepc", csr[12'h141], 64'h8000_0204);
    check_eq("t2_scause", csr[12'h142], 64'd8);
    check_eq("t2_stval", csr[12'h143], 64'h55);
    check_eq("t2_sstatus", csr[12'h100], 64'h20);
    check_eq("t2_mepc_kept", csr[12'h341], 64'h8000_3000);

    // Vectored interrupt from S, medeleg all ones
    csr_set(12'h302, '1);
    csr_set(12'h305, 64'h8000_0001);
    csr_set(12'h300, 64'h0);
    set_trap(64'h8000_0000_0000_0007, 64'h8000_0400, 64'h0);
    run_seq(rcyc, rpc, rmode, rdy_after, busy1);
    check_eq("t3_pc", rpc, 64'h8000_001C);
    check_eq("t3_mode", rmode, 2'b11);
    check_eq("t3_mcause", csr[12'h342], 64'h8000_0000_0000_0007);
    check_eq("t3_mepc", csr[12'h341], 64'h8000_0400);
    check_eq("t3_mstatus", csr[12'h300], 64'h800);

    // MRET to S
    csr_set(12'h341, 64'h8000_2000);
    csr_set(12'h300, 64'h880);
    bus.XRET_S = 1'b0; bus.XRET_VALID = 1'b1;
    run_seq(rcyc, rpc, rmode, rdy_after, busy1);
    check_eq("t4_cyc", rcyc, 4);
    check_eq("t4_pc", rpc, 64'h8000_2000);
    check_eq("t4_mode", rmode, 2'b01);
    check_eq("t4_mstatus", csr[12'h300], 64'h88);

    // Simultaneous trap and SRET, both held
    csr_set(12'h302, 64'h0);
    csr_set(12'h305, 64'h8000_1000);
    csr_set(12'h300, 64'h0);
    csr_set(12'h100, 64'h100);
    csr_set(12'h141, 64'h8040_0000);
    set_trap(64'd2, 64'h8000_0600, 64'h0);
    bus.XRET_S = 1'b1; bus.XRET_VALID = 1'b1;
    r1_cyc = -1; r2_cyc = -1; r1_pc = '0; r2_pc = '0; r1_mode = '0; r2_mode = '0;
    rdy8 = 1'b0; busy9 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c == 1) bus.TRAP_VALID = 1'b0;
      if (c == 8) rdy8 = bus.READY;
      if (c == 9) begin busy9 = bus.BUSY; bus.XRET_VALID = 1'b0; end
      if (bus.REDIRECT_VALID) begin
        if (r1_cyc < 0) begin r1_cyc = c; r1_pc = bus.REDIRECT_PC; r1_mode = bus.MODE; end
        else if (r2_cyc < 0) begin r2_cyc = c; r2_pc = bus.REDIRECT_PC; r2_mode = bus.MODE; end
      end
      @(negedge CLK);
    end
    bus.XRET_VALID = 1'b0;
    check_eq("t5_r1_cyc", r1_cyc, 7);
    check_eq("t5_r1_pc", r1_pc, 64'h8000_1000);
    check_eq("t5_r1_mode", r1_mode, 2'b11);
    check_eq("t5_ready8", rdy8, 1);
    check_eq("t5_busy9", busy9, 1);
    check_eq("t5_r2_cyc", r2_cyc, 12);
    check_eq("t5_r2_pc", r2_pc, 64'h8040_0000);
    check_eq("t5_r2_mode", r2_mode, 2'b01);
    check_eq("t5_mstatus", csr[12'h300], 64'h800);
    check_eq("t5_sstatus", csr[12'h100], 64'h20);

    // Reset during WR_CAUSE
    set_trap(64'd2, 64'h8000_0700, 64'h0);
    for (int c = 0; c < 4; c++) begin
      if (c == 1) bus.TRAP_VALID = 1'b0;
      @(negedge CLK);
    end
    check_eq("t6_wa_cause", bus.CSR_WA, 12'h342);
    check_eq("t6_wcmd_cause", bus.CSR_WCMD, 2'b01);
    check_eq("t6_mode_pre", bus.MODE, 2'b01);
    #1 RSTn = 1'b0;
    #1;
    check_eq("t6_ready", bus.READY, 1);
    check_eq("t6_busy", bus.BUSY, 0);
    check_eq("t6_wcmd", bus.CSR_WCMD, 0);
    check_eq("t6_wa", bus.CSR_WA, 0);
    check_eq("t6_redir", bus.REDIRECT_VALID, 0);
    check_eq("t6_mode", bus.MODE, 2'b11);
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    n_redir = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.REDIRECT_VALID) n_redir++;
      @(negedge CLK);
    end
    check_eq("t6_ready_after", bus.READY, 1);
    check_eq("t6_no_redir", n_redir, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
